serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 88 ++++++++
 tb/tb_serial_subtractor.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - bin subtractor, LSB first, one bit per clock
// Start/busy/done handshake; diff and bout only change on the final RUN edge.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] ra, rb, wd;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic             d, brw_next, last;

  // One full-subtractor cell, fed from the bottom of the operand shift registers.
  assign d        = ra[0] ^ rb[0] ^ brw;
  assign brw_next = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & brw);
  assign last     = (cnt == CW'(WIDTH - 1));

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ra   <= '0;
      rb   <= '0;
      brw  <= 1'b0;
      wd   <= '0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ra  <= a;
            rb  <= b;
            brw <= bin;
            wd  <= '0;
            cnt <= '0;
          end
        end
        RUN: begin
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          brw <= brw_next;
          wd  <= {d, wd[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          // Publish the result including the bit being processed on this edge.
          if (last) begin
            diff <= {d, wd[WIDTH-1:1]};
            bout <= brw_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed checks of serial_subtractor at WIDTH=4 and WIDTH=8
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start4, bin4, busy4, done4, bout4;
  logic [3:0] a4, b4, diff4;
  logic       start8, bin8, busy8, done8, bout8;
  logic [7:0] a8, b8, diff8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
  );

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Pulse start for one edge while idle, then expect done 4 cycles after acceptance.
  task automatic do_op4(input logic [3:0] ia, input logic [3:0] ib, input logic ibin,
                        input logic [3:0] ed, input logic eb, input string tag);
    int lat;
    a4 = ia; b4 = ib; bin4 = ibin; start4 = 1'b1;
    tick;
    start4 = 1'b0;
    chk({tag, " busy"}, {31'd0, busy4}, 32'd1);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick;
      if (done4) begin lat = i; break; end
    end
    chk({tag, " latency"}, lat, 32'd4);
    chk({tag, " result"}, {27'd0, bout4, diff4}, {27'd0, eb, ed});
    tick;
    chk({tag, " idle"}, {30'd0, busy4, done4}, 32'd0);
  endtask

  initial begin
    int nd, lat, gap, last_cyc, idx, ai, bi, ci;
    logic hold_ok;
    logic [4:0] prev, res;
    int exp_q[$];

    rst = 1'b1;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    tick; tick;
    chk("reset w4", {25'd0, busy4, done4, bout4, diff4}, 32'd0);
    chk("reset w8", {21'd0, busy8, done8, bout8, diff8}, 32'd0);
    rst = 1'b0;
    tick;

    do_op4(4'd10, 4'd13, 1'b0, 4'b1101, 1'b1, "basic borrow");
    do_op4(4'd13, 4'd10, 1'b0, 4'b0011, 1'b0, "no borrow");
    do_op4(4'd15, 4'd15, 1'b0, 4'b0000, 1'b0, "equal");
    do_op4(4'd0,  4'd0,  1'b1, 4'b1111, 1'b1, "borrow in");

    // Ignored start: operands change and start pulses during RUN.
    prev = {bout4, diff4};
    a4 = 4'd9; b4 = 4'd3; bin4 = 1'b0; start4 = 1'b1;
    tick;
    start4 = 1'b0; a4 = 4'd1; b4 = 4'd2;
    nd = 0; lat = 0; hold_ok = 1'b1; res = '0;
    for (int i = 1; i <= 15; i++) begin
      tick;
      start4 = (i == 1);
      if (done4) begin
        nd++;
        if (nd == 1) begin lat = i; res = {bout4, diff4}; end
      end else if (nd == 0 && {bout4, diff4} !== prev) begin
        hold_ok = 1'b0;
      end
    end
    start4 = 1'b0;
    chk("ign done count", nd, 32'd1);
    chk("ign latency", lat, 32'd4);
    chk("ign result", {27'd0, res}, {27'd0, 1'b0, 4'd6});
    chk("ign hold", {31'd0, hold_ok}, 32'd1);

    // Reset on the 2nd RUN edge.
    a4 = 4'd5; b4 = 4'd7; bin4 = 1'b0; start4 = 1'b1;
    tick;
    start4 = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst busy", {31'd0, busy4}, 32'd0);
    chk("rst done", {31'd0, done4}, 32'd0);
    chk("rst diff", {28'd0, diff4}, 32'd0);
    chk("rst bout", {31'd0, bout4}, 32'd0);
    nd = 0;
    repeat (10) begin
      tick;
      if (done4) nd++;
    end
    chk("rst no done", nd, 32'd0);
    do_op4(4'd5, 4'd7, 1'b0, 4'b1110, 1'b1, "after reset");

    // Exhaustive sweep with start held high; acceptance is seen as busy rising.
    idx = 0;
    a4 = 4'd0; b4 = 4'd0; bin4 = 1'b0; start4 = 1'b1;
    nd = 0; last_cyc = -100;
    for (int cyc = 1; cyc <= 5000 && nd < 512; cyc++) begin
      logic was_busy;
      was_busy = busy4;
      tick;
      if (done4) begin
        chk("sweep result", {27'd0, bout4, diff4}, (exp_q.size() > 0) ? exp_q.pop_front() : -1);
        if (nd > 0) begin
          gap = cyc - last_cyc;
          chk("sweep gap ok", {31'd0, (gap >= 5 && gap <= 6)}, 32'd1);
        end
        last_cyc = cyc;
        nd++;
      end
      if (busy4 && !was_busy && idx < 512) begin
        ai = a4; bi = b4; ci = bin4;
        exp_q.push_back(((ai < bi + ci) ? 16 : 0) | ((ai - bi - ci) & 15));
        idx++;
        if (idx < 512) begin
          a4 = idx[7:4]; b4 = idx[3:0]; bin4 = idx[8];
        end else begin
          start4 = 1'b0;
        end
      end
    end
    start4 = 1'b0;
    chk("sweep done count", nd, 32'd512);
    repeat (3) tick;

    // WIDTH=8 instance.
    a8 = 8'h00; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    tick;
    start8 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      tick;
      if (done8) begin lat = i; break; end
    end
    chk("w8 latency", lat, 32'd8);
    chk("w8 result", {23'd0, bout8, diff8}, {23'd0, 1'b1, 8'hFF});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
